// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART byte sequencer.
// Holds the sequencer FSM state type and the default parameter values
// used by uart_byte_sequencer and tick_divider.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        ST_ARM      = 3'd0,
        ST_PRESSED  = 3'd1,
        ST_REQ      = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_WAIT_REL = 3'd4,
        ST_ADVANCE  = 3'd5
    } seq_state_t;

    localparam int unsigned DEF_DATA_W    = 32'd8;
    localparam logic [7:0]  DEF_START_VAL = 8'h41;
    localparam logic [7:0]  DEF_END_VAL   = 8'h5A;
    localparam int unsigned DEF_STEP      = 32'd1;
    localparam int unsigned DEF_CLK_DIV   = 32'd1160;
    localparam int unsigned DEF_BURST_LEN = 32'd16;
    localparam int unsigned DEF_COUNT_W   = 32'd16;

endpackage

// File: rtl/tick_divider.sv
// Sequencer tick generator.
// Counts clk_raw cycles 0..CLK_DIV-1 and raises tick for exactly the cycle
// in which the count sits at CLK_DIV-1.
// Ports:
//   clk_raw - single clock
//   rst     - synchronous active-high reset (count and tick cleared)
//   tick    - one-cycle pulse every CLK_DIV cycles
module tick_divider
    import uart_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_raw,
    input  logic rst,
    output logic tick
);

    localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 32'd1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 32'd2);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Divider count plus a registered tick that is high while cnt_r == CNT_LAST.
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            // Registering one count early keeps tick aligned with CNT_LAST.
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_byte_sequencer.sv
// Byte-stimulus generator for UART transmitter bring-up.
// Walks START_VAL..END_VAL in STEP increments and offers each value to a
// transmitter over a four-phase send/ack handshake, one byte per button
// press (mode=0) or BURST_LEN bytes per press (mode=1). The FSM only moves
// on divider ticks.
// Ports:
//   clk_raw    - single clock
//   rst        - synchronous active-high reset
//   btn        - debounced button level
//   mode       - 0 single-step, 1 burst (latched when a press is accepted)
//   ack        - transmitter acknowledge
//   data       - byte offered to the transmitter, stable while send=1
//   send       - transmit request
//   busy       - high whenever the FSM is not waiting in ARM
//   sent_count - bytes acknowledged, wrapping
module uart_byte_sequencer
    import uart_seq_pkg::*;
#(
    parameter int unsigned        DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0]  START_VAL = DEF_START_VAL,
    parameter logic [DATA_W-1:0]  END_VAL   = DEF_END_VAL,
    parameter int unsigned        STEP      = DEF_STEP,
    parameter int unsigned        CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned        BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned        COUNT_W   = DEF_COUNT_W
) (
    input  logic               clk_raw,
    input  logic               rst,
    input  logic               btn,
    input  logic               mode,
    input  logic               ack,
    output logic [DATA_W-1:0]  data,
    output logic               send,
    output logic               busy,
    output logic [COUNT_W-1:0] sent_count
);

    localparam int unsigned        BURST_W    = $clog2(BURST_LEN + 32'd1);
    localparam logic [BURST_W-1:0] BURST_INIT = BURST_W'(BURST_LEN);
    localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);
    localparam logic [DATA_W:0]    STEP_EXT   = (DATA_W + 1)'(STEP);
    localparam logic [DATA_W:0]    END_EXT    = {1'b0, END_VAL};

    // Next value in the range; the extra bit catches carry-out so an
    // overflowing sum also wraps back to START_VAL.
    function automatic logic [DATA_W-1:0] next_value(input logic [DATA_W-1:0] cur);
        logic [DATA_W:0] sum;
        sum = {1'b0, cur} + STEP_EXT;
        if (sum > END_EXT) begin
            next_value = START_VAL;
        end else begin
            next_value = sum[DATA_W-1:0];
        end
    endfunction

    seq_state_t         state_r, state_s;
    logic [DATA_W-1:0]  data_r, data_s;
    logic               send_r, send_s;
    logic               busy_r, busy_s;
    logic [COUNT_W-1:0] count_r, count_s;
    logic [BURST_W-1:0] burst_r, burst_s;
    logic               tick_s;

    tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_divider (
        .clk_raw (clk_raw),
        .rst     (rst),
        .tick    (tick_s)
    );

    // Next-state and next-output logic; everything holds between ticks.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        send_s  = send_r;
        count_s = count_r;
        burst_s = burst_r;
        if (tick_s) begin
            case (state_r)
                ST_ARM: begin
                    if (btn) begin
                        state_s = ST_PRESSED;
                        burst_s = mode ? BURST_INIT : BURST_ONE;
                    end else begin
                        state_s = ST_ARM;
                    end
                end
                ST_PRESSED: begin
                    // Wait for release so a held button fires only once.
                    if (!btn) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_PRESSED;
                    end
                end
                ST_REQ: begin
                    send_s  = 1'b1;
                    state_s = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack) begin
                        send_s  = 1'b0;
                        count_s = count_r + COUNT_W'(1);
                        state_s = ST_WAIT_REL;
                    end else begin
                        state_s = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_REL: begin
                    if (!ack) begin
                        state_s = ST_ADVANCE;
                    end else begin
                        state_s = ST_WAIT_REL;
                    end
                end
                ST_ADVANCE: begin
                    data_s = next_value(data_r);
                    // <= also covers a zero counter, so it can never underflow.
                    if (burst_r <= BURST_ONE) begin
                        burst_s = {BURST_W{1'b0}};
                        state_s = ST_ARM;
                    end else begin
                        burst_s = burst_r - BURST_ONE;
                        state_s = ST_REQ;
                    end
                end
                default: begin
                    send_s  = 1'b0;
                    state_s = ST_ARM;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        busy_s = (state_s != ST_ARM);
    end

    // State and output registers.
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            state_r <= ST_ARM;
            data_r  <= START_VAL;
            send_r  <= 1'b0;
            busy_r  <= 1'b0;
            count_r <= {COUNT_W{1'b0}};
            burst_r <= {BURST_W{1'b0}};
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            send_r  <= send_s;
            busy_r  <= busy_s;
            count_r <= count_s;
            burst_r <= burst_s;
        end
    end

    assign data       = data_r;
    assign send       = send_r;
    assign busy       = busy_r;
    assign sent_count = count_r;

endmodule

// File: tb/tb_uart_byte_sequencer.sv
// Bench for uart_byte_sequencer: two instances (defaults with burst of 5,
// and a narrow wrapping range 0x41..0x43 step 2), a transmitter ack model,
// a per-cycle comparison against a range-walk model, and directed scenarios.
module tb_uart_byte_sequencer;

    localparam int CLK_DIV   = 4;
    localparam int BURST_LEN = 5;

    logic        clk;
    logic        rst;
    logic        btn;
    logic        mode;
    logic [1:0]  ack_v;
    logic [1:0]  send_v;
    logic [1:0]  busy_v;
    logic [7:0]  data_v [2];
    logic [15:0] cnt_v  [2];

    int n_checks = 0;
    int n_fail   = 0;
    int ack_len  = 0;
    int ack_age  [2];

    logic       rst_seen;
    logic [1:0] send_prev;
    logic [7:0] mdl_data [2];
    int         mdl_cnt  [2];
    logic [7:0] off0 [$];
    logic [7:0] off1 [$];
    int         rise0 [$];
    int         cyc = 0;

    uart_byte_sequencer #(
        .CLK_DIV   (CLK_DIV),
        .BURST_LEN (BURST_LEN)
    ) dut0 (
        .clk_raw (clk), .rst (rst), .btn (btn), .mode (mode), .ack (ack_v[0]),
        .data (data_v[0]), .send (send_v[0]), .busy (busy_v[0]), .sent_count (cnt_v[0])
    );

    uart_byte_sequencer #(
        .START_VAL (8'h41),
        .END_VAL   (8'h43),
        .STEP      (2),
        .CLK_DIV   (CLK_DIV),
        .BURST_LEN (BURST_LEN)
    ) dut1 (
        .clk_raw (clk), .rst (rst), .btn (btn), .mode (mode), .ack (ack_v[1]),
        .data (data_v[1]), .send (send_v[1]), .busy (busy_v[1]), .sent_count (cnt_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Range walk from the rules: add STEP, anything past END_VAL restarts at 0x41.
    function automatic logic [7:0] model_next(input int i, input logic [7:0] cur);
        int lim;
        int stp;
        int s;
        lim = (i == 0) ? 'h5A : 'h43;
        stp = (i == 0) ? 1 : 2;
        s   = int'(cur) + stp;
        return (s > lim) ? 8'h41 : 8'(s);
    endfunction

    // Transmitter: ack straight after send rises, drop once send is low and
    // ack has been high for at least ack_len cycles.
    initial begin
        ack_v   = 2'b00;
        ack_age[0] = 0;
        ack_age[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (ack_v[i]) ack_age[i]++;
                if (!ack_v[i] && send_v[i]) begin
                    ack_v[i]   = 1'b1;
                    ack_age[i] = 0;
                end else if (ack_v[i] && !send_v[i] && ack_age[i] >= ack_len) begin
                    ack_v[i] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) rst_seen <= rst;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst_seen) begin
                mdl_data[i] = 8'h41;
                mdl_cnt[i]  = 0;
                check("reset_send", int'(send_v[i]), 0);
                check("reset_data", int'(data_v[i]), 'h41);
                check("reset_busy", int'(busy_v[i]), 0);
                check("reset_count", int'(cnt_v[i]), 0);
            end else begin
                if (send_v[i] && !send_prev[i]) begin
                    check("offer_data", int'(data_v[i]), int'(mdl_data[i]));
                    if (i == 0) begin
                        off0.push_back(data_v[i]);
                        rise0.push_back(cyc);
                    end else begin
                        off1.push_back(data_v[i]);
                    end
                end
                if (!send_v[i] && send_prev[i]) begin
                    mdl_cnt[i]  = (mdl_cnt[i] + 1) % 65536;
                    mdl_data[i] = model_next(i, mdl_data[i]);
                end
                if (send_v[i]) begin
                    check("data_stable", int'(data_v[i]), int'(mdl_data[i]));
                    check("busy_with_send", int'(busy_v[i]), 1);
                end
                check("sent_count", int'(cnt_v[i]), mdl_cnt[i]);
            end
            send_prev[i] = send_v[i];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold);
        btn = 1'b1;
        step(hold);
        btn = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        off0.delete();
        off1.delete();
        rise0.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        step(2);
        while (busy_v !== 2'b00 && k < budget) begin
            step(1);
            k++;
        end
        check(name, (k < budget) ? 1 : 0, 1);
    endtask

    task automatic wait_rises(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (off0.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(name, (k < budget) ? 1 : 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        btn  = 1'b0;
        mode = 1'b0;
        step(3);
        check("pin_reset_data", int'(data_v[0]), 'h41);
        check("pin_reset_send", int'(send_v[0]), 0);
        check("pin_reset_count", int'(cnt_v[1]), 0);
        rst = 1'b0;

        // Single-step, three presses.
        for (int k = 0; k < 3; k++) begin
            press(8);
            wait_idle("single_idle_timeout", 400);
            check("single_busy_low", int'(busy_v), 0);
        end
        check("single_n_offered", off0.size(), 3);
        check("single_byte0", int'(off0[0]), 'h41);
        check("single_byte1", int'(off0[1]), 'h42);
        check("single_byte2", int'(off0[2]), 'h43);
        check("single_count", int'(cnt_v[0]), 3);
        check("wrap_byte0", int'(off1[0]), 'h41);
        check("wrap_byte1", int'(off1[1]), 'h43);
        check("wrap_byte2", int'(off1[2]), 'h41);
        check("wrap_count", int'(cnt_v[1]), 3);

        // Burst of five; a second press mid-burst is ignored.
        do_reset();
        mode = 1'b1;
        press(8);
        mode = 1'b0;
        wait_rises("burst_rise_timeout", 2, 200);
        check("burst_busy", int'(busy_v), 3);
        press(8);
        wait_idle("burst_idle_timeout", 800);
        step(100);
        check("burst_n_offered", off0.size(), 5);
        for (int j = 0; j < 5; j++) begin
            check("burst_byte", int'(off0[j]), 'h41 + j);
        end
        for (int j = 1; j < 5; j++) begin
            check("burst_spacing", rise0[j] - rise0[j-1], 4 * CLK_DIV);
        end
        check("burst_wrap_b3", int'(off1[3]), 'h43);
        check("burst_wrap_b4", int'(off1[4]), 'h41);
        check("burst_count", int'(cnt_v[0]), 5);

        // Ack held high for 10 ticks.
        do_reset();
        ack_len = 10 * CLK_DIV;
        mode = 1'b1;
        press(8);
        mode = 1'b0;
        wait_rises("hold_rise_timeout", 1, 200);
        step(20);
        check("hold_send_low", int'(send_v[0]), 0);
        check("hold_ack_high", int'(ack_v[0]), 1);
        check("hold_data_frozen", int'(data_v[0]), 'h41);
        check("hold_count", int'(cnt_v[0]), 1);
        wait_idle("hold_idle_timeout", 2000);
        ack_len = 0;
        check("hold_gap", rise0[1] - rise0[0], 13 * CLK_DIV);
        check("hold_n_offered", off0.size(), 5);

        // Reset while send is high on the third burst byte.
        do_reset();
        mode = 1'b1;
        press(8);
        mode = 1'b0;
        wait_rises("midrst_rise_timeout", 3, 300);
        check("midrst_send_high", int'(send_v[0]), 1);
        rst = 1'b1;
        step(1);
        check("midrst_send", int'(send_v[0]), 0);
        check("midrst_data", int'(data_v[0]), 'h41);
        check("midrst_count", int'(cnt_v[0]), 0);
        check("midrst_busy", int'(busy_v[0]), 0);
        rst = 1'b0;
        off0.delete();
        off1.delete();
        rise0.delete();
        step(4);
        press(8);
        wait_rises("restart_rise_timeout", 1, 200);
        check("restart_byte", int'(off0[0]), 'h41);
        wait_idle("restart_idle_timeout", 400);
        check("restart_count", int'(cnt_v[0]), 1);

        // Button held for 50 ticks sends exactly one byte.
        do_reset();
        btn = 1'b1;
        step(50 * CLK_DIV);
        btn = 1'b0;
        wait_idle("held_idle_timeout", 400);
        step(60);
        check("held_n_offered", off0.size(), 1);
        check("held_count", int'(cnt_v[0]), 1);
        check("held_wrap_count", int'(cnt_v[1]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
